// File: rtl/uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Frame length in bit periods: start + data + optional parity + stop.
   function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
      return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is presented combinationally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // Same index with differing wrap bits means the writer has lapped the reader.
   assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign empty   = (r_wr_ptr == r_rd_ptr);
   assign w_push  = wr_en && !full;
   assign w_pop   = rd_en && !empty;
   assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames go out back-to-back while words are queued.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 12,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [DATA_BITS-1:0] wr_data,
   output logic                 full,
   output logic                 empty,
   output logic                 overflow,
   output logic                 busy,
   output logic                 tx_line
);

   localparam int   TIMER_W = $clog2(CLKS_PER_BIT);
   localparam int   BIT_W   = $clog2(DATA_BITS);
   localparam logic HAS_PAR = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
   localparam logic ODD_PAR = (PARITY == PAR_ODD);

   localparam logic [2:0] S_IDLE  = ST_IDLE;
   localparam logic [2:0] S_START = ST_START;
   localparam logic [2:0] S_DATA  = ST_DATA;
   localparam logic [2:0] S_PAR   = ST_PAR;
   localparam logic [2:0] S_STOP  = ST_STOP;

   logic [2:0]           r_state;
   logic [TIMER_W-1:0]   r_timer;
   logic [BIT_W-1:0]     r_bit_idx;
   logic                 r_stop_cnt;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_overflow;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par;

   logic                 w_full;
   logic                 w_empty;
   logic [DATA_BITS-1:0] w_head;
   logic                 w_bit_end;
   logic                 w_last_bit;
   logic                 w_last_stop;
   logic                 w_pop;
   logic                 w_data_end;
   logic                 w_par_bit;

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (w_pop),
      .rd_data (w_head),
      .full    (w_full),
      .empty   (w_empty)
   );

   assign w_bit_end   = (r_timer == TIMER_W'(CLKS_PER_BIT - 1));
   assign w_last_bit  = (r_bit_idx == BIT_W'(DATA_BITS - 1));
   assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
   assign w_data_end  = (r_state == S_DATA) && w_bit_end;
   // Pop from IDLE, or at the end of the final stop bit to chain the next frame without a gap.
   assign w_pop       = !w_empty && ((r_state == S_IDLE) ||
                        ((r_state == S_STOP) && w_bit_end && w_last_stop));
   assign w_par_bit   = r_par ^ r_shift[0] ^ ODD_PAR;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_bit_idx  <= '0;
         r_stop_cnt <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= wr_en && w_full;
         if (r_state == S_IDLE || w_bit_end) r_timer <= '0;
         else                                r_timer <= r_timer + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_state <= S_START;
                  r_tx    <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_tx      <= r_shift[0];
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (!w_last_bit) begin
                     r_bit_idx <= r_bit_idx + 1'b1;
                     r_tx      <= r_shift[1];
                  end else if (HAS_PAR) begin
                     r_state <= S_PAR;
                     r_tx    <= w_par_bit;
                  end else begin
                     r_state    <= S_STOP;
                     r_tx       <= 1'b1;
                     r_stop_cnt <= 1'b0;
                  end
               end
            end
            S_PAR: begin
               if (w_bit_end) begin
                  r_state    <= S_STOP;
                  r_tx       <= 1'b1;
                  r_stop_cnt <= 1'b0;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (!w_last_stop) begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end else if (!w_empty) begin
                     r_state <= S_START;
                     r_tx    <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Payload shifter and running parity; loaded on every pop, no reset needed.
   always_ff @(posedge clk) begin
      if (w_pop) begin
         r_shift <= w_head;
         r_par   <= 1'b0;
      end else if (w_data_end) begin
         r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
         r_par   <= r_par ^ r_shift[0];
      end
   end

   assign full     = w_full;
   assign empty    = w_empty;
   assign overflow = r_overflow;
   assign busy     = r_busy;
   assign tx_line  = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: default, even/odd parity with two stops, and 5-bit fast configurations.
module tb_uart_tx_fifo;

   logic       clk;
   logic       rst;
   logic [3:0] wr_en_v;
   logic [7:0] wr_data;

   logic full0, empty0, ovf0, busy0, tx0;
   logic full1, empty1, ovf1, busy1, tx1;
   logic full2, empty2, ovf2, busy2, tx2;
   logic full3, empty3, ovf3, busy3, tx3;

   int checks   = 0;
   int failures = 0;

   uart_tx_fifo u0 (
      .clk(clk), .rst(rst), .wr_en(wr_en_v[0]), .wr_data(wr_data),
      .full(full0), .empty(empty0), .overflow(ovf0), .busy(busy0), .tx_line(tx0)
   );

   uart_tx_fifo #(.PARITY(2), .STOP_BITS(2)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en_v[1]), .wr_data(wr_data),
      .full(full1), .empty(empty1), .overflow(ovf1), .busy(busy1), .tx_line(tx1)
   );

   uart_tx_fifo #(.PARITY(1), .STOP_BITS(2)) u2 (
      .clk(clk), .rst(rst), .wr_en(wr_en_v[2]), .wr_data(wr_data),
      .full(full2), .empty(empty2), .overflow(ovf2), .busy(busy2), .tx_line(tx2)
   );

   uart_tx_fifo #(.DATA_BITS(5), .CLKS_PER_BIT(4)) u3 (
      .clk(clk), .rst(rst), .wr_en(wr_en_v[3]), .wr_data(wr_data[4:0]),
      .full(full3), .empty(empty3), .overflow(ovf3), .busy(busy3), .tx_line(tx3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic tx_of(input int i);
      case (i)
         0:       return tx0;
         1:       return tx1;
         2:       return tx2;
         default: return tx3;
      endcase
   endfunction

   function automatic logic busy_of(input int i);
      case (i)
         0:       return busy0;
         1:       return busy1;
         2:       return busy2;
         default: return busy3;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic wr(input int i, input logic [7:0] d);
      wr_data = d;
      wr_en_v = 4'b0001 << i;
      @(negedge clk);
      wr_en_v = 4'b0000;
   endtask

   // Sample each bit half a clock after it starts and count contiguous busy cycles.
   // bits[0] is the first bit on the line; skip = busy cycles already elapsed.
   task automatic frame_check(input int i, input logic [63:0] bits, input int nbits,
                              input int cpb, input int exp_busy, input int skip,
                              input string tag);
      int t;
      int c;
      t = 0;
      while (tx_of(i) !== 1'b0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      c = skip;
      while (busy_of(i) === 1'b1 && c < 2000) begin
         if ((c % cpb) == 0 && (c / cpb) < nbits)
            check($sformatf("%s_bit%0d", tag, c / cpb), {31'd0, tx_of(i)}, {31'd0, bits[c / cpb]});
         c++;
         @(negedge clk);
      end
      check($sformatf("%s_busy_cycles", tag), c, exp_busy);
      check($sformatf("%s_idle_line", tag), {31'd0, tx_of(i)}, 32'd1);
   endtask

   initial begin
      rst     = 1'b0;
      wr_en_v = 4'b0000;
      wr_data = 8'h00;
      repeat (3) @(negedge clk);

      check("rst_tx",    {31'd0, tx0},    32'd1);
      check("rst_busy",  {31'd0, busy0},  32'd0);
      check("rst_full",  {31'd0, full0},  32'd0);
      check("rst_empty", {31'd0, empty0}, 32'd1);
      check("rst_ovf",   {31'd0, ovf0},   32'd0);
      check("rst_tx3",   {31'd0, tx3},    32'd1);

      // Release and write on the very first edge with reset high.
      rst = 1'b1;
      wr(0, 8'h05);
      check("lat_empty_fall", {31'd0, empty0}, 32'd0);
      check("lat_tx_still_hi", {31'd0, tx0},   32'd1);
      check("lat_busy_still_lo", {31'd0, busy0}, 32'd0);
      @(negedge clk);
      check("lat_tx_fall",   {31'd0, tx0},    32'd0);
      check("lat_busy_rise", {31'd0, busy0},  32'd1);
      check("lat_empty_pop", {31'd0, empty0}, 32'd1);
      frame_check(0, 64'(10'b1_00000101_0), 10, 12, 120, 0, "f05");

      // Three consecutive writes: one busy cycle already elapsed when the last write returns.
      wr(0, 8'h05);
      wr(0, 8'h03);
      wr(0, 8'h0C);
      frame_check(0, 64'(30'b1_00001100_0_1_00000011_0_1_00000101_0), 30, 12, 360, 1, "f3x");
      check("f3x_empty", {31'd0, empty0}, 32'd1);

      // Five back-to-back writes: first popped, four stored; sixth overflows.
      wr(0, 8'h01);
      wr(0, 8'h02);
      wr(0, 8'h03);
      wr(0, 8'h04);
      wr(0, 8'h05);
      check("ovf_full", {31'd0, full0}, 32'd1);
      check("ovf_pre",  {31'd0, ovf0},  32'd0);
      wr(0, 8'h06);
      check("ovf_pulse",     {31'd0, ovf0},  32'd1);
      check("ovf_full_kept", {31'd0, full0}, 32'd1);
      @(negedge clk);
      check("ovf_one_cycle", {31'd0, ovf0},  32'd0);
      frame_check(0, 64'(50'b1_00000101_0_1_00000100_0_1_00000011_0_1_00000010_0_1_00000001_0),
                  50, 12, 600, 5, "fovf");
      check("fovf_empty", {31'd0, empty0}, 32'd1);

      // Reset mid data bit 0 of 0x0C with a second word still queued.
      wr(0, 8'h0C);
      wr(0, 8'h55);
      repeat (18) @(negedge clk);
      check("mid_tx",    {31'd0, tx0},    32'd0);
      check("mid_busy",  {31'd0, busy0},  32'd1);
      check("mid_empty", {31'd0, empty0}, 32'd0);
      #2 rst = 1'b0;
      #1;
      check("arst_tx",    {31'd0, tx0},    32'd1);
      check("arst_busy",  {31'd0, busy0},  32'd0);
      check("arst_empty", {31'd0, empty0}, 32'd1);
      check("arst_full",  {31'd0, full0},  32'd0);
      @(negedge clk);
      rst = 1'b1;
      wr(0, 8'h03);
      check("post_rst_empty", {31'd0, empty0}, 32'd0);
      frame_check(0, 64'(10'b1_00000011_0), 10, 12, 120, 0, "fpost");
      check("fpost_empty", {31'd0, empty0}, 32'd1);

      // Even parity, two stop bits: 0x05 has two ones, parity bit 0.
      wr(1, 8'h05);
      frame_check(1, 64'(12'b11_0_00000101_0), 12, 12, 144, 0, "feven");

      // Odd parity, two stop bits: parity bit 1.
      wr(2, 8'h05);
      frame_check(2, 64'(12'b11_1_00000101_0), 12, 12, 144, 0, "fodd");

      // Five data bits at four clocks per bit.
      wr(3, 8'h1F);
      frame_check(3, 64'(7'b1_11111_0), 7, 4, 28, 0, "f5b");
      check("f5b_ovf", {31'd0, ovf3}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised, synthesisable UART transmitter with an input FIFO, replacing the hand-timed bit-banged serial stimulus currently driven into `rx_line_uart` of `single_cycle_p2`. It accepts words from a producer (bench sequencer or core MMIO store), buffers them, and serialises them LSB-first with configurable data width, parity, stop bits and bit period. Frames are sent back-to-back while the FIFO holds data.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 12: clock cycles per serial bit, ≥ 2 (12 × 10 ns = 120 ns bit).
- `DATA_BITS`, default 8: payload width, 5..9.
- `PARITY`, default 0: 0 none, 1 odd, 2 even.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe.
- `wr_data`  in  DATA_BITS  word to send.
- `full`  out  1  FIFO holds FIFO_DEPTH words.
- `empty`  out  1  FIFO holds no words.
- `overflow`  out  1  one-cycle pulse: `wr_en` while `full`.
- `busy`  out  1  high while a frame is on the line.
- `tx_line`  out  1  serial output, idle high.

## Operation
- Write accepted on a rising edge with `wr_en && !full`. A write while full is dropped and pulses `overflow`; FIFO contents are unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE, FIFO non-empty: pop head, load shift register, go to START.
  - START: line 0 for one bit period.
  - DATA: DATA_BITS bits, LSB first.
  - PAR: only if PARITY≠0. Bit = XOR of data bits, inverted for odd.
  - STOP: line 1 for STOP_BITS bit periods.
- At end of STOP: FIFO non-empty → pop and go directly to START (no idle gap). Otherwise go to IDLE.
- Bit timer counts 0..CLKS_PER_BIT-1. Bit index counts 0..DATA_BITS-1. Stop counter counts 0..STOP_BITS-1.
- Pop and write in the same cycle:
  - Both take effect; count is unchanged.
  - Write-when-full is judged on pre-edge `full`, so it is rejected even if a pop occurs in the same cycle.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.

## Timing
- Reset (`rst` low, asynchronous):
  - `tx_line`=1, `busy`=0, `full`=0, `empty`=1, `overflow`=0.
  - FSM to IDLE; FIFO pointers cleared.
  - Applies immediately, including mid-frame; the partial frame is abandoned.
- Release is synchronous in effect: the first write is accepted on the first rising edge with `rst` high.
- Latency: a word written into an empty FIFO at edge k while IDLE:
  - `empty` falls after edge k.
  - `tx_line` falls and `busy` rises after edge k+1.
- `empty` returns to 1 after the pop edge.
- All outputs are registered; `tx_line` has no combinational path from inputs.
- `busy` falls after the edge ending the last stop bit, only if no next word is pending.

## Structure
- Package `uart_pkg`: state enum (IDLE, START, DATA, PAR, STOP); parity constants PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2; function returning frame length in bit periods.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Pointers carry an extra wrap bit so full and empty can be distinguished.
  - Same clock/reset as the parent.
- Top level holds the FSM, bit timer, shift register and parity accumulator.

## Test plan
- Defaults; write 0x05 once → `tx_line` = 0,1,0,1,0,0,0,0,0,1, each 12 cycles; `busy` high exactly 120 cycles.
- Write 0x05, 0x03, 0x0C on consecutive cycles → three frames, 360 contiguous busy cycles; data bits 10100000, 11000000, 00110000.
- PARITY=2, STOP_BITS=2; send 0x05 → parity bit 0, then 24 high cycles. PARITY=1 → parity bit 1. Frame = 144 cycles.
- FIFO_DEPTH=4, writes while the first frame transmits:
  - 5 back-to-back writes → 1 popped + 4 stored, `full`=1.
  - 6th write → `overflow` pulse 1 cycle; word not transmitted.
- DATA_BITS=5, CLKS_PER_BIT=4; send 0x1F → 0,1,1,1,1,1,1; 28 cycles.
- Assert `rst` low mid-DATA of 0x0C → `tx_line`=1 and `empty`=1 immediately. After release, a write of 0x03 transmits cleanly.
